icache_fetch: RTL and testbench
===============================

Name: icache_fetch

Overview:
- Direct-mapped instruction cache on the fetch side of the pipeline.
- Takes the fetch PC and returns a 32-bit instruction on a hit.
- On a miss it is the initiator of the line-fill protocol toward the instruction memory: it issues a request, waits for the valid pulse, captures the 128-bit line, and then serves the fetch.
- It also provides a flush and hit/miss performance counters.

Parameters:
- XLEN, 32, PC and instruction width.
- SETS, 4, number of cache lines; power of 2, ≥2; IDX = log2(SETS).
- MEM_LINES, 8, lines in the backing memory; F_mem_addr width = log2(MEM_LINES) = 3.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- F_req  in  1  fetch wants the instruction at F_pc this cycle.
- F_pc  in  XLEN  fetch byte address; bits [1:0] ignored.
- F_flush  in  1  invalidate all lines (e.g. after self-modifying code or a fence).
- F_inst  out  XLEN  instruction; valid only when F_inst_valid=1.
- F_inst_valid  out  1  combinational hit indication.
- F_stall  out  1  F_req & ~F_inst_valid.
- F_mem_req  out  1  registered one-cycle request pulse to memory.
- F_mem_addr  out  3  registered memory line index.
- F_mem_inst  in  128  returned line; word w is bits [32w+31:32w].
- F_mem_valid  in  1  one-cycle pulse; F_mem_inst is valid in that cycle only.
- hit_count  out  CNT_W  hit cycles, saturating.
- miss_count  out  CNT_W  misses issued, saturating.

Behaviour:
- Address split:
  - word = F_pc[3:2]
  - index = F_pc[4+IDX-1:4]
  - tag = F_pc[XLEN-1:4+IDX]
  - memory line = F_pc[6:4], truncated to 3 bits; aliasing beyond 128 bytes is a memory property, not a cache property.
- Storage: per set, a valid bit, a tag, and 4×32 data words.
- hit = valid[index] & (tag_arr[index] == tag).
- F_inst_valid = F_req & hit & (state==IDLE) & ~F_flush, combinational.
- F_inst = data[index][word] whenever hit; otherwise F_inst is don't-care.
- FSM has two states, IDLE and WAIT.
- IDLE:
  - If F_req & ~hit & ~F_flush: at the edge, set F_mem_req<=1, F_mem_addr<=F_pc[6:4], latch miss_index and miss_tag, increment miss_count, and go to WAIT.
  - Otherwise F_mem_req<=0.
- WAIT:
  - F_mem_req<=0. The request is exactly one cycle wide and is never re-issued while a fill is outstanding. Memory ignores requests while busy, so a second pulse is a protocol violation.
  - On F_mem_valid: if the fill is not cancelled, write all 4 words, the tag, and valid=1 into miss_index. Then go to IDLE.
  - F_inst_valid=0 throughout WAIT. F_stall follows F_req.
- Miss penalty:
  - A miss detected in cycle T asserts F_mem_req in T+1.
  - With memory LATENCY=3, F_mem_valid arrives in T+4.
  - The same F_pc hits in T+5 (T+LATENCY+2).
- F_pc may change during WAIT. The fill always targets the latched miss_index/miss_tag. Lookup after returning to IDLE uses the current F_pc.
- Flush:
  - F_flush clears all valid bits at the edge. In its cycle it forces F_inst_valid=0, and no miss is issued.
  - Flush in WAIT sets a cancel flag. The FSM stays in WAIT until F_mem_valid, discards the data (valid stays 0), clears cancel, and returns to IDLE.
  - Flush in the same cycle as F_mem_valid behaves as a cancelled fill: the line ends invalid.
- Spurious F_mem_valid in IDLE is ignored.
- Counters:
  - hit_count increments on each cycle with F_inst_valid=1; a multi-cycle stall on the same PC counts only on the hit cycle.
  - Both counters saturate at all-ones.
- Reset values:
  - State IDLE; all valid bits 0; cancel 0.
  - F_mem_req=0, F_mem_addr=0, hit_count=0, miss_count=0.
  - Tag and data arrays are not reset.
  - Reset mid-WAIT abandons the fill. The memory shares rst, so no stale F_mem_valid follows.

Test Plan:
- Cold miss:
  - Stimulus: after reset, F_req=1, F_pc=0x00. The memory holds line 0 = {0x…03,0x…02,0x…01,0x…00}.
  - Required: F_mem_req is a single pulse with F_mem_addr=0. F_stall stays high until F_inst_valid=1 with F_inst=word0, in cycle T+5. miss_count=1.
- Line reuse:
  - Stimulus: after the fill, sweep F_pc 0x0,0x4,0x8,0xC.
  - Required: 4 consecutive hits with F_inst = words 0..3, no F_mem_req, hit_count=4.
- Conflict:
  - Stimulus: fetch 0x00, then 0x40 (same index 0 with SETS=4, different tag), then 0x00.
  - Required: three misses with F_mem_addr=0, 4, 0 respectively. miss_count=3.
- PC change in WAIT:
  - Stimulus: miss on 0x10, then switch F_pc to 0x20 during WAIT.
  - Required: set 1 is filled. The next cycle misses on 0x20 (F_mem_addr=2). A later fetch of 0x10 hits.
- Flush:
  - Stimulus: fill line 0, assert F_flush for 1 cycle, then fetch 0x00.
  - Required: a miss and a new request.
  - Stimulus: assert F_flush during WAIT.
  - Required: no valid line after F_mem_valid. The next fetch re-misses.
- Reset mid-fill:
  - Stimulus: assert rst in WAIT.
  - Required: F_mem_req=0, counters 0, all lines invalid. The next fetch misses normally.

Source files
------------

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache for the fetch stage. It serves hits combinationally
// and fetches missing 128-bit lines from instruction memory with a request/valid handshake.
module icache_fetch #(
  parameter int XLEN      = 32,
  parameter int SETS      = 4,
  parameter int MEM_LINES = 8,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         F_req,
  input  logic [XLEN-1:0]              F_pc,
  input  logic                         F_flush,
  output logic [XLEN-1:0]              F_inst,
  output logic                         F_inst_valid,
  output logic                         F_stall,
  output logic                         F_mem_req,
  output logic [$clog2(MEM_LINES)-1:0] F_mem_addr,
  input  logic [4*XLEN-1:0]            F_mem_inst,
  input  logic                         F_mem_valid,
  output logic [CNT_W-1:0]             hit_count,
  output logic [CNT_W-1:0]             miss_count
);

  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = XLEN - 4 - IDX;
  localparam int MA_W  = $clog2(MEM_LINES);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             state_q;
  logic [SETS-1:0]    valid_q;
  logic               cancel_q;
  logic [IDX-1:0]     miss_idx_q;
  logic [TAG_W-1:0]   miss_tag_q;
  logic               mem_req_q;
  logic [MA_W-1:0]    mem_addr_q;
  logic [CNT_W-1:0]   hit_cnt_q;
  logic [CNT_W-1:0]   miss_cnt_q;
  logic [CNT_W-1:0]   hit_cnt_d;

  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [XLEN-1:0]    data_q [SETS][4];

  logic [1:0]         word;
  logic [IDX-1:0]     idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               miss_issue;
  logic               fill_we;
  logic               unused_pc_bits;

  assign word = F_pc[3:2];
  assign idx  = F_pc[4+IDX-1:4];
  assign tag  = F_pc[XLEN-1:4+IDX];
  assign unused_pc_bits = ^F_pc[1:0];

  assign hit          = valid_q[idx] & (tag_q[idx] == tag);
  assign F_inst_valid = F_req & hit & (state_q == S_IDLE) & ~F_flush;
  assign F_inst       = data_q[idx][word];
  assign F_stall      = F_req & ~F_inst_valid;

  assign miss_issue = (state_q == S_IDLE) & F_req & ~hit & ~F_flush;
  // A flush arriving together with the returning line cancels that fill too.
  assign fill_we    = (state_q == S_WAIT) & F_mem_valid & ~cancel_q & ~F_flush;

  assign hit_cnt_d = (F_inst_valid && hit_cnt_q != '1) ? hit_cnt_q + 1'b1 : hit_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      cancel_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      mem_req_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (miss_issue) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= F_pc[4+MA_W-1:4];
            miss_idx_q <= idx;
            miss_tag_q <= tag;
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (F_mem_valid) begin
            if (fill_we) valid_q[miss_idx_q] <= 1'b1;
            cancel_q <= 1'b0;
            state_q  <= S_IDLE;
          end else if (F_flush) begin
            cancel_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // Flush wins over any valid bit set above.
      if (F_flush) valid_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[miss_idx_q] <= miss_tag_q;
      for (int w = 0; w < 4; w++) begin
        data_q[miss_idx_q][w] <= F_mem_inst[w*XLEN +: XLEN];
      end
    end
  end

  assign F_mem_req  = mem_req_q;
  assign F_mem_addr = mem_addr_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch with a 3-cycle-latency line memory model.
module tb_icache_fetch;

  logic         clk;
  logic         rst;
  logic         F_req;
  logic [31:0]  F_pc;
  logic         F_flush;
  logic [31:0]  F_inst;
  logic         F_inst_valid;
  logic         F_stall;
  logic         F_mem_req;
  logic [2:0]   F_mem_addr;
  logic [127:0] F_mem_inst;
  logic         F_mem_valid;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  logic         mem_valid_q;
  logic         spur;
  logic [1:0]   mem_cnt;
  logic [2:0]   mem_line;

  int n_checks = 0;
  int n_errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  assign F_mem_valid = mem_valid_q | spur;

  icache_fetch dut (
    .clk(clk), .rst(rst), .F_req(F_req), .F_pc(F_pc), .F_flush(F_flush),
    .F_inst(F_inst), .F_inst_valid(F_inst_valid), .F_stall(F_stall),
    .F_mem_req(F_mem_req), .F_mem_addr(F_mem_addr), .F_mem_inst(F_mem_inst),
    .F_mem_valid(F_mem_valid), .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [2:0] line, input logic [1:0] w);
    return {16'hC0DE, 5'd0, line, 6'd0, w};
  endfunction

  // Memory: request seen at the edge closing cycle T+1, valid pulse in cycle T+4.
  always @(posedge clk) begin
    if (rst) begin
      mem_cnt     <= 2'd0;
      mem_valid_q <= 1'b0;
      mem_line    <= 3'd0;
      F_mem_inst  <= '0;
    end else begin
      mem_valid_q <= 1'b0;
      if (mem_cnt == 2'd1) begin
        mem_valid_q <= 1'b1;
        mem_cnt     <= 2'd0;
        for (int w = 0; w < 4; w++) F_mem_inst[32*w +: 32] <= mem_word(mem_line, 2'(w));
      end else if (mem_cnt > 2'd1) begin
        mem_cnt <= mem_cnt - 2'd1;
      end
      if (F_mem_req && mem_cnt == 2'd0) begin
        mem_cnt  <= 2'd2;
        mem_line <= F_mem_addr;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Holds F_req on pc until a hit; enter and leave at a negedge.
  task automatic fetch(input string tag, input logic [31:0] pc, input int exp_lat,
                       input int exp_reqs, input logic [2:0] exp_addr);
    int lat = -1;
    int nreq = 0;
    int bad = 0;
    logic [2:0]  addr = 3'd0;
    logic [31:0] inst = 32'd0;
    F_req = 1'b1;
    F_pc  = pc;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (F_mem_req) begin
        nreq++;
        addr = F_mem_addr;
      end
      if (F_stall !== ~F_inst_valid) bad++;
      if (F_inst_valid) begin
        lat  = c;
        inst = F_inst;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    exp_misses += exp_reqs;
    if (lat >= 0) exp_hits++;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_nreq"}, nreq, exp_reqs);
    if (exp_reqs > 0) check({tag, "_addr"}, {29'd0, addr}, {29'd0, exp_addr});
    check({tag, "_inst"}, inst, mem_word(pc[6:4], pc[3:2]));
    check({tag, "_stall"}, bad, 0);
    check({tag, "_hitcnt"}, {16'd0, hit_count}, exp_hits);
    check({tag, "_misscnt"}, {16'd0, miss_count}, exp_misses);
  endtask

  // Miss on pc with a one-cycle flush in WAIT cycle fc (1..4; 4 = same cycle as valid).
  task automatic miss_flush(input string tag, input logic [31:0] pc, input int fc);
    int nreq = 0;
    int bad = 0;
    F_req = 1'b1;
    F_pc  = pc;
    for (int i = 0; i < 5; i++) begin
      F_flush = (i == fc);
      #1;
      if (F_mem_req) nreq++;
      if (F_inst_valid) bad++;
      @(negedge clk);
    end
    F_flush = 1'b0;
    exp_misses++;
    check({tag, "_nreq"}, nreq, 1);
    check({tag, "_novalid"}, bad, 0);
  endtask

  initial begin
    rst = 1'b1; F_req = 1'b0; F_pc = '0; F_flush = 1'b0; spur = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mem_req", F_mem_req, 0);
    check("rst_mem_addr", F_mem_addr, 0);
    check("rst_hitcnt", hit_count, 0);
    check("rst_misscnt", miss_count, 0);
    check("rst_inst_valid", F_inst_valid, 0);
    @(negedge clk);

    fetch("cold", 32'h00, 5, 1, 3'd0);
    fetch("reuse0", 32'h00, 0, 0, 3'd0);
    fetch("reuse4", 32'h04, 0, 0, 3'd0);
    fetch("reuse8", 32'h08, 0, 0, 3'd0);
    fetch("reuseC", 32'h0C, 0, 0, 3'd0);

    fetch("conf40", 32'h40, 5, 1, 3'd4);
    fetch("conf00", 32'h00, 5, 1, 3'd0);

    // Switch PC during the fill of 0x10.
    F_req = 1'b1; F_pc = 32'h10;
    #1 check("pcsw_stall", F_stall, 1);
    @(negedge clk);
    F_pc = 32'h20;
    exp_misses++;
    #1;
    check("pcsw_req", F_mem_req, 1);
    check("pcsw_addr", F_mem_addr, 1);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      #1;
      check("pcsw_wait_iv", F_inst_valid, 0);
      check("pcsw_wait_req", F_mem_req, 0);
    end
    @(negedge clk);
    fetch("pcsw20", 32'h20, 5, 1, 3'd2);
    fetch("pcsw10", 32'h10, 0, 0, 3'd0);

    // Flush in IDLE against a resident line.
    F_req = 1'b1; F_pc = 32'h00; F_flush = 1'b1;
    #1;
    check("flush_iv", F_inst_valid, 0);
    check("flush_stall", F_stall, 1);
    @(negedge clk);
    F_flush = 1'b0;
    fetch("flush00", 32'h00, 5, 1, 3'd0);
    fetch("flush10", 32'h10, 5, 1, 3'd1);

    miss_flush("fw1", 32'h40, 1);
    fetch("fw1_re", 32'h40, 5, 1, 3'd4);
    miss_flush("fw4", 32'h50, 4);
    fetch("fw4_re", 32'h50, 5, 1, 3'd5);

    // Reset in the middle of a fill.
    F_req = 1'b1; F_pc = 32'h30;
    @(negedge clk);
    #1 check("rstw_req", F_mem_req, 1);
    @(negedge clk);
    rst = 1'b1; F_req = 1'b0;
    @(negedge clk);
    rst = 1'b0; spur = 1'b1;
    exp_hits = 0; exp_misses = 0;
    #1;
    check("rstw_mem_req", F_mem_req, 0);
    check("rstw_hitcnt", hit_count, 0);
    check("rstw_misscnt", miss_count, 0);
    @(negedge clk);
    spur = 1'b0;
    fetch("rstw40", 32'h40, 5, 1, 3'd4);
    fetch("rstw30", 32'h30, 5, 1, 3'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
